// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned BCD_MAX   = 9;
  localparam int unsigned BCD_RADIX = 10;

  // Active-low 7-segment codes, leftmost bit = segment a, rightmost = g.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001101;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Map one BCD value to its segment code; non-decimal values show blank.
  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add with decimal correction and operand range check.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] d,
  output logic       co,
  output logic       bad
);

  logic [4:0] sum;

  // Binary sum, then subtract the radix when it exceeds one decimal digit.
  always_comb begin
    sum = 5'(a) + 5'(b) + 5'(ci);
    bad = (a > 4'(BCD_MAX)) || (b > 4'(BCD_MAX));
    if (sum > 5'(BCD_MAX)) begin
      d  = 4'(sum - 5'(BCD_RADIX));
      co = 1'b1;
    end else begin
      d  = sum[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_seq_adder.sv
// Digit-serial multi-digit BCD adder with start/busy/done handshake.
// Optional 7-segment output HEX when BCD_SEG_EN is defined.
module bcd_seq_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   S,
  output logic                  cout,
`ifdef BCD_SEG_EN
  output logic                  err,
  output logic [7*(DIGITS+1)-1:0] HEX
`else
  output logic                  err
`endif
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t state, state_n;

  logic [DIGITS-1:0][3:0] a_q, a_n, b_q, b_n, wres, wres_n;
  logic [IW-1:0]          idx, idx_n;
  logic                   carry, carry_n, werr, werr_n;
  logic [4*DIGITS-1:0]    s_n;
  logic                   cout_n, err_n, busy_n, done_n;

  logic [3:0] dig_d;
  logic       dig_co, dig_bad;

  bcd_digit_add u_digit (
    .a   (a_q[idx]),
    .b   (b_q[idx]),
    .ci  (carry),
    .d   (dig_d),
    .co  (dig_co),
    .bad (dig_bad)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    wres_n  = wres;
    idx_n   = idx;
    carry_n = carry;
    werr_n  = werr;
    s_n     = S;
    cout_n  = cout;
    err_n   = err;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          a_n     = A;
          b_n     = B;
          carry_n = cin;
          idx_n   = '0;
          werr_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = ADD;
        end
      end
      ADD: begin
        wres_n[idx] = dig_d;
        carry_n     = dig_co;
        werr_n      = werr | dig_bad;
        idx_n       = idx + 1'b1;
        if (idx == IW'(DIGITS - 1)) begin
          s_n     = wres_n;
          cout_n  = dig_co;
          err_n   = werr | dig_bad;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          busy_n  = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q   <= '0;
      b_q   <= '0;
      wres  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      werr  <= 1'b0;
      S     <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      a_q   <= a_n;
      b_q   <= b_n;
      wres  <= wres_n;
      idx   <= idx_n;
      carry <= carry_n;
      werr  <= werr_n;
      S     <= s_n;
      cout  <= cout_n;
      err   <= err_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

`ifdef BCD_SEG_EN
  // Segment decode of the registered result; everything blank on err.
  always_comb begin
    HEX = '1;
    if (!err) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        HEX[7*k +: 7] = seg_code(S[4*k +: 4]);
      end
      HEX[7*DIGITS +: 7] = seg_code({3'b000, cout});
    end
  end
`endif

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Self-checking bench for bcd_seq_adder (DIGITS = 2), directed plus random.
module tb_bcd_seq_adder;

  localparam int D = 2;
  localparam int W = 4 * D;

  logic         Clock = 1'b0;
  logic         Reset, start, cin;
  logic [W-1:0] A, B;
  logic         busy, done, cout, err;
  logic [W-1:0] S;
`ifdef BCD_SEG_EN
  logic [7*(D+1)-1:0] HEX;
`endif

  int vectors = 0;
  int miscompares = 0;

  bcd_seq_adder #(.DIGITS(D)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .start (start),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .cout  (cout),
`ifdef BCD_SEG_EN
    .err   (err),
    .HEX   (HEX)
`else
    .err   (err)
`endif
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal arithmetic for valid operands, digit rule when any digit is out of range.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output logic [W-1:0] s, output logic co, output logic e);
    int av, bv, t, carry, pw, x;
    e = 1'b0;
    for (int i = 0; i < D; i++)
      if (int'(a[4*i +: 4]) > 9 || int'(b[4*i +: 4]) > 9) e = 1'b1;
    s = '0;
    if (!e) begin
      av = 0; bv = 0; pw = 1;
      for (int i = D - 1; i >= 0; i--) begin
        av = av * 10 + int'(a[4*i +: 4]);
        bv = bv * 10 + int'(b[4*i +: 4]);
        pw = pw * 10;
      end
      x  = av + bv + int'(c);
      co = (x >= pw);
      x  = x % pw;
      for (int i = 0; i < D; i++) begin
        s[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end else begin
      carry = int'(c);
      for (int i = 0; i < D; i++) begin
        t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + carry;
        if (t > 9) begin s[4*i +: 4] = 4'((t - 10) % 16); carry = 1; end
        else       begin s[4*i +: 4] = 4'(t);             carry = 0; end
      end
      co = (carry != 0);
    end
  endtask

`ifdef BCD_SEG_EN
  logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001101, 7'b0000000, 7'b0000100};
  function automatic logic [6:0] seg(input int v);
    return (v > 9) ? 7'b1111111 : segtab[v];
  endfunction
  function automatic logic [7*(D+1)-1:0] hex_exp(input logic [W-1:0] s, input logic co, input logic e);
    logic [7*(D+1)-1:0] h;
    h = '1;
    if (!e) begin
      for (int k = 0; k < D; k++) h[7*k +: 7] = seg(int'(s[4*k +: 4]));
      h[7*D +: 7] = seg(int'(co));
    end
    return h;
  endfunction
`endif

  // One complete operation with cycle-by-cycle handshake checks.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W-1:0] es;
    logic         ec, ee;
    model(a, b, c, es, ec, ee);
    @(negedge Clock);
    A = a; B = b; cin = c; start = 1'b1;
    @(negedge Clock);
    start = 1'b0; A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
    chk("busy_c1", 64'(busy), 64'd1);
    chk("done_c1", 64'(done), 64'd0);
    for (int i = 1; i < D; i++) begin
      @(negedge Clock);
      chk("busy_mid", 64'(busy), 64'd1);
    end
    @(negedge Clock);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_done", 64'(busy), 64'd0);
    chk("S", 64'(S), 64'(es));
    chk("cout", 64'(cout), 64'(ec));
    chk("err", 64'(err), 64'(ee));
`ifdef BCD_SEG_EN
    chk("HEX", 64'(HEX), 64'(hex_exp(es, ec, ee)));
`endif
    @(negedge Clock);
    chk("done_low", 64'(done), 64'd0);
    chk("S_hold", 64'(S), 64'(es));
  endtask

  initial begin
    int n, pulses;
    logic [W-1:0] ra, rb;
    Reset = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_S", 64'(S), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
`ifdef BCD_SEG_EN
    chk("rst_HEX", 64'(HEX), 64'({(D+1){7'b0000001}}));
`endif

    do_add(8'h45, 8'h38, 1'b0);
`ifdef BCD_SEG_EN
    chk("hex_s1", 64'(HEX), 64'({7'b0000001, 7'b0000000, 7'b0000110}));
`endif
    chk("s1_S", 64'(S), 64'h83);
    do_add(8'h99, 8'h99, 1'b1);
    chk("s2_S", 64'(S), 64'h99);
    chk("s2_cout", 64'(cout), 64'd1);
    do_add(8'h00, 8'h00, 1'b0);
    chk("s2b_cout", 64'(cout), 64'd0);
    do_add(8'h1A, 8'h01, 1'b0);
    chk("s3_S", 64'(S), 64'h21);
    chk("s3_err", 64'(err), 64'd1);
`ifdef BCD_SEG_EN
    chk("hex_s3", 64'(HEX), 64'({(D+1){7'b1111111}}));
`endif

    // Start during ADD is ignored.
    @(negedge Clock);
    A = 8'h12; B = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge Clock);
    A = 8'h99; B = 8'h99; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    pulses = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < D + 4; i++) begin
      @(negedge Clock);
      if (done === 1'b1) pulses++;
    end
    chk("s4_pulses", 64'(pulses), 64'd1);
    chk("s4_S", 64'(S), 64'h46);

    // Reset aborts an in-flight add.
    @(negedge Clock);
    A = 8'h77; B = 8'h11; start = 1'b1;
    @(negedge Clock);
    start = 1'b0; Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_S", 64'(S), 64'd0);
    pulses = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < D + 3; i++) begin
      @(negedge Clock);
      if (done === 1'b1) pulses++;
    end
    chk("s5_nodone", 64'(pulses), 64'd0);
    do_add(8'h50, 8'h50, 1'b0);
    chk("s5b_S", 64'(S), 64'h00);
    chk("s5b_cout", 64'(cout), 64'd1);

    // Held start restarts immediately after DONE.
    @(negedge Clock);
    A = 8'h21; B = 8'h12; cin = 1'b0; start = 1'b1;
    n = 0;
    do begin @(negedge Clock); n++; end while (done !== 1'b1 && n < 20);
    chk("held_first", 64'(n), 64'(D + 1));
    n = 0;
    do begin @(negedge Clock); n++; end while (done !== 1'b1 && n < 20);
    chk("held_gap", 64'(n), 64'(D + 2));
    start = 1'b0;
    chk("held_S", 64'(S), 64'h33);
    @(negedge Clock);
    chk("held_idle", 64'(busy), 64'd0);

    // Random operands, mostly valid BCD.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      do_add(ra, rb, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
